// File: rtl/comb_interp_pkg.sv
// Shared types and constants for the four-phase comb interpolator commutator.
package comb_interp_pkg;

  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } state_e;

endpackage

// File: rtl/comb_interp_fmt.sv
// Phase-output formatter: arithmetic right shift by SHIFT, then narrowing to OUT_W.
// Build option COMB_INTERP_ROUND_SAT_EN selects round-half-up with saturation instead of wrap.
module comb_interp_fmt #(
  parameter int PH_W  = 20,
  parameter int OUT_W = 12,
  parameter int SHIFT = 6
) (
  input  logic signed [PH_W-1:0]  ph,
  output logic signed [OUT_W-1:0] out_data
);

`ifdef COMB_INTERP_ROUND_SAT_EN
  localparam logic signed [PH_W:0] HALF = {{PH_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [PH_W:0] rounded;
  logic signed [PH_W:0] shifted;
  logic                 fits;

  always_comb begin
    rounded = {ph[PH_W-1], ph} + HALF;
    shifted = rounded >>> SHIFT;
    // The narrowed value is exact only when every dropped bit matches the kept sign bit.
    fits    = (&shifted[PH_W:OUT_W-1]) || !(|shifted[PH_W:OUT_W-1]);
    if (fits) begin
      out_data = shifted[OUT_W-1:0];
    end else if (shifted[PH_W]) begin
      out_data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_data = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic signed [PH_W-1:0] shifted;
  logic                   unused_high;

  assign shifted     = ph >>> SHIFT;
  assign out_data    = shifted[OUT_W-1:0];
  assign unused_high = ^shifted[PH_W-1:OUT_W];
`endif

endmodule

// File: rtl/comb_interp_commutator.sv
// Controller/commutator for the four-phase comb interpolator: launches each input sample into
// phases E1..E4 and serialises their outputs E1 first. Build option: COMB_INTERP_ROUND_SAT_EN.
module comb_interp_commutator
  import comb_interp_pkg::*;
#(
  parameter int IN_W   = 11,
  parameter int PH_W   = 20,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 6,
  parameter int PH_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    ph_ce,
  output logic signed [IN_W-1:0]  ph_sample,
  input  logic signed [PH_W-1:0]  ph0,
  input  logic signed [PH_W-1:0]  ph1,
  input  logic signed [PH_W-1:0]  ph2,
  input  logic signed [PH_W-1:0]  ph3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [PHASE_W-1:0]      out_phase
);

  localparam int CNT_W = $clog2(PH_LAT + 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ph_ce_q, ph_ce_d;
  logic signed [IN_W-1:0] ph_sample_q, ph_sample_d;
  logic signed [PH_W-1:0] bank_q [NUM_PHASES];
  logic signed [PH_W-1:0] bank_d [NUM_PHASES];
  logic [PHASE_W-1:0]     out_phase_q, out_phase_d;
  logic                   in_hs, out_hs, launch;

  // The last output beat may overlap with accepting the next input.
  assign in_ready  = (state_q == IDLE) ||
                     (state_q == EMIT && out_phase_q == LAST_PHASE && out_ready);
  assign out_valid = (state_q == EMIT);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  assign ph_ce     = ph_ce_q;
  assign ph_sample = ph_sample_q;
  assign out_phase = out_phase_q;

  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_ce_d     = 1'b0;
    ph_sample_d = ph_sample_q;
    bank_d      = bank_q;
    out_phase_d = out_phase_q;
    launch      = 1'b0;

    unique case (state_q)
      IDLE: launch = in_hs;
      WAIT: begin
        if (cnt_q == '0) begin
          bank_d[0]   = ph0;
          bank_d[1]   = ph1;
          bank_d[2]   = ph2;
          bank_d[3]   = ph3;
          out_phase_d = '0;
          state_d     = EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (out_phase_q != LAST_PHASE) begin
            out_phase_d = out_phase_q + PHASE_W'(1);
          end else begin
            state_d = IDLE;
            launch  = in_hs;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d     = WAIT;
      ph_ce_d     = 1'b1;
      ph_sample_d = in_data;
      cnt_d       = CNT_W'(PH_LAT);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values whatever the block order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ph_ce_q     <= 1'b0;
      ph_sample_q <= '0;
      out_phase_q <= '0;
      // NOTE: the bank is a memory but is reset, because out_data must read zero right after reset.
      for (int i = 0; i < NUM_PHASES; i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_ce_q     <= ph_ce_d;
      ph_sample_q <= ph_sample_d;
      out_phase_q <= out_phase_d;
      for (int i = 0; i < NUM_PHASES; i++) bank_q[i] <= bank_d[i];
    end
  end

  comb_interp_fmt #(
    .PH_W (PH_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_fmt (
    .ph      (bank_q[out_phase_q]),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_comb_interp_commutator.sv
// Self-checking bench for comb_interp_commutator: directed scenarios plus random traffic,
// scored against a queue-based reference of the expected output stream.
module tb_comb_interp_commutator;

  localparam int IN_W   = 11;
  localparam int PH_W   = 20;
  localparam int OUT_W  = 12;
  localparam int SHIFT  = 6;
  localparam int PH_LAT = 1;
  localparam int LAT    = PH_LAT + 2;
  localparam int GAP    = 4 + PH_LAT + 1;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    ph_ce;
  logic signed [IN_W-1:0]  ph_sample;
  logic signed [PH_W-1:0]  ph_w [4];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_phase;

  int total = 0;
  int bad   = 0;

  // Phase-filter stub: fixed values, or the sample times a per-phase gain.
  bit use_fix;
  int fix  [4];
  int mult [4] = '{511, -300, 173, -509};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ph_w[k] = use_fix ? PH_W'(fix[k]) : PH_W'(int'(ph_sample) * mult[k]);
    end
  end

  comb_interp_commutator #(
    .IN_W  (IN_W),
    .PH_W  (PH_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .PH_LAT(PH_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ph_ce    (ph_ce),
    .ph_sample(ph_sample),
    .ph0      (ph_w[0]),
    .ph1      (ph_w[1]),
    .ph2      (ph_w[2]),
    .ph3      (ph_w[3]),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_phase(out_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference formatting from the arithmetic definition.
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int fmt_model(input int ph);
    int v;
    int lo;
    int hi;
    lo = -(1 << (OUT_W - 1));
    hi = (1 << (OUT_W - 1)) - 1;
`ifdef COMB_INTERP_ROUND_SAT_EN
    v = floor_div(ph + (1 << (SHIFT - 1)), 1 << SHIFT);
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`else
    v = floor_div(ph, 1 << SHIFT);
    v = ((v % (1 << OUT_W)) + (1 << OUT_W)) % (1 << OUT_W);
    if (v > hi) v = v - (1 << OUT_W);
`endif
    return v;
  endfunction

  function automatic int ph_of(input int k, input int s);
    return use_fix ? fix[k] : s * mult[k];
  endfunction

  // Scoreboard: samples every cycle just before the rising edge.
  int exp_q [$];
  int beat, acc_cyc, last_in, mcyc, rst_cnt, rst_seen;
  bit acc_prev, prev_valid, prev_ready;
  int prev_data, prev_phase;

  always @(posedge clk) if (rst) rst_cnt++;

  always begin
    @(negedge clk);
    #4;
    mcyc++;
    if (rst_cnt != rst_seen) begin
      rst_seen = rst_cnt;
      exp_q.delete();
      beat       = 0;
      acc_prev   = 0;
      prev_valid = 0;
      prev_ready = 1;
    end
    if (!rst) begin
      check("ph_ce", int'(ph_ce), int'(acc_prev));
      if (acc_prev) check("ph_sample", int'(ph_sample), last_in);
      check("in_ready", int'(in_ready),
            int'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
      if (exp_q.size() == 0) check("valid_idle", int'(out_valid), 0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), prev_data);
        check("hold_phase", int'(out_phase), prev_phase);
      end
      if (out_valid && !prev_valid) check("latency", mcyc - acc_cyc, LAT);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("data", int'(out_data), exp_q.pop_front());
        check("phase", int'(out_phase), beat);
        beat = (beat + 1) % 4;
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(fmt_model(ph_of(k, int'(in_data))));
        acc_prev = 1;
        acc_cyc  = mcyc;
        last_in  = int'(in_data);
      end else begin
        acc_prev = 0;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = int'(out_data);
      prev_phase = int'(out_phase);
    end
  end

  // Directed/random driver: drives on the falling edge, observes 4 time units later.
  int dcyc;

  task automatic step();
    @(negedge clk);
    dcyc++;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      step();
      settle();
      n++;
    end while ((out_valid || !in_ready) && n < 40);
    check(tag, int'(!out_valid && in_ready), 1);
  endtask

  // One sample from IDLE with out_ready high; checks exact beat timing and values.
  task automatic group(input int e [4]);
    step();
    in_valid = 1'b1;
    in_data  = IN_W'($urandom);
    settle();
    check("g_accept", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    settle();
    check("g_ce", int'(ph_ce), 1);
    repeat (PH_LAT) begin
      step();
      settle();
      check("g_ce_once", int'(ph_ce), 0);
      check("g_wait_valid", int'(out_valid), 0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      settle();
      check("g_valid", int'(out_valid), 1);
      check("g_phase", int'(out_phase), k);
      check("g_data", int'(out_data), e[k]);
    end
    step();
    settle();
    check("g_end_valid", int'(out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int e [4];
    int n, last_acc, held;
    bit acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    use_fix   = 1'b1;
    fix       = '{0, 0, 0, 0};

    repeat (3) step();
    settle();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_ph_ce", int'(ph_ce), 0);
    check("rst_ph_sample", int'(ph_sample), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_phase", int'(out_phase), 0);
    step();
    rst = 1'b0;

    // Basic group with fixed phase outputs.
    fix = '{64, 128, 192, 256};
    e   = '{1, 2, 3, 4};
    group(e);

    // Rounding / truncation corner values.
    fix = '{96, -96, 524287, 0};
`ifdef COMB_INTERP_ROUND_SAT_EN
    e = '{2, -1, 2047, 0};
`else
    e = '{1, -2, -1, 0};
`endif
    group(e);

    // Input stall while idle.
    use_fix = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("stall_ce", int'(ph_ce), 0);
      check("stall_valid", int'(out_valid), 0);
      check("stall_ready", int'(in_ready), 1);
    end

    // Backpressure at phase 1 for five cycles.
    step();
    in_valid = 1'b1;
    in_data  = IN_W'($urandom);
    settle();
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      settle();
      if (!(out_valid && out_phase == 2'd0)) step();
      n++;
    end while (!(out_valid && out_phase == 2'd0) && n < 20);
    step();
    out_ready = 1'b0;
    settle();
    check("bp_phase", int'(out_phase), 1);
    held = int'(out_data);
    repeat (4) begin
      step();
      settle();
      check("bp_valid", int'(out_valid), 1);
      check("bp_hold_phase", int'(out_phase), 1);
      check("bp_hold_data", int'(out_data), held);
      check("bp_in_ready", int'(in_ready), 0);
    end
    step();
    out_ready = 1'b1;
    settle();
    check("bp_resume_phase", int'(out_phase), 1);
    wait_idle("bp_drain");

    // Back-to-back inputs overlapping with beat 3.
    step();
    in_valid = 1'b1;
    in_data  = IN_W'($urandom);
    settle();
    last_acc = dcyc;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        step();
        settle();
        n++;
      end
      check("b2b_accept", int'(in_ready), 1);
      if (g > 0) begin
        check("b2b_gap", dcyc - last_acc, GAP);
        check("b2b_beat3", int'(out_phase), 3);
        check("b2b_beat3_valid", int'(out_valid), 1);
      end
      last_acc = dcyc;
      step();
      in_valid = (g < 2);
      in_data  = IN_W'($urandom);
      settle();
    end
    wait_idle("b2b_drain");

    // Reset in the middle of a group at phase 2.
    step();
    in_valid = 1'b1;
    in_data  = IN_W'($urandom);
    settle();
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      settle();
      if (!(out_valid && out_phase == 2'd2)) step();
      n++;
    end while (!(out_valid && out_phase == 2'd2) && n < 20);
    check("mid_rst_reach", int'(out_phase), 2);
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_phase", int'(out_phase), 0);
    check("mid_rst_ph_sample", int'(ph_sample), 0);
    fix     = '{-4000, 70000, -524288, 131100};
    use_fix = 1'b1;
    for (int k = 0; k < 4; k++) e[k] = fmt_model(fix[k]);
    group(e);

    // Random traffic with random backpressure.
    use_fix = 1'b0;
    acc     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = IN_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      acc = in_valid && in_ready;
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    settle();
    wait_idle("rand_drain");
    check("rand_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
